// File: rtl/mem_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dump_reader
//  Description : Reads a word range from a byte-wide synchronous memory and
//                streams it out as (address, little-endian word) records.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_dump_reader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_word,
  output logic              out_last
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_word_addr;
  logic [CNT_W-1:0]  r_remaining;
  logic [2:0]        r_byte_idx;
  logic [31:0]       r_word;
  logic              w_last;
  logic              w_rd_phase;

  assign w_last     = (r_remaining == CNT_W'(1));
  assign w_rd_phase = (r_byte_idx != 3'd4);
  assign mem_addr   = r_word_addr + ADDR_W'(r_byte_idx);
  assign out_addr   = r_word_addr;
  assign out_word   = r_word;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (word_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        busy      = 1'b1;
        mem_rd_en = w_rd_phase;
        if (!w_rd_phase) begin
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = w_last;
        if (out_ready) begin
          w_state_nxt = w_last ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read data lags the strobe by one cycle, so index k fills lane k-1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_word_addr <= '0;
      r_remaining <= '0;
      r_byte_idx  <= '0;
      r_word      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_word_addr <= base_addr;
            r_remaining <= word_count;
            r_byte_idx  <= '0;
          end
        end
        S_READ: begin
          case (r_byte_idx)
            3'd1:    r_word[7:0]   <= mem_rdata;
            3'd2:    r_word[15:8]  <= mem_rdata;
            3'd3:    r_word[23:16] <= mem_rdata;
            3'd4:    r_word[31:24] <= mem_rdata;
            default: ;
          endcase
          r_byte_idx <= w_rd_phase ? (r_byte_idx + 3'd1) : 3'd0;
        end
        S_EMIT: begin
          if (out_ready && !w_last) begin
            r_word_addr <= r_word_addr + ADDR_W'(4);
            r_remaining <= r_remaining - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_dump_reader
//  Description : Randomized self-checking bench for mem_dump_reader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dump_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        busy, done, mem_rd_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_addr;
  logic [31:0] out_word;
  logic        out_last;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  logic [7:0] mem_ovr [logic [31:0]];
  logic [7:0] mem_seed = 8'h5A;

  logic [31:0] rd_q [$];
  logic [31:0] ra_q [$];
  logic [31:0] rw_q [$];
  logic        rl_q [$];
  int          rc_q [$];
  int          done_cnt = 0, done_cyc = -1, first_valid_cyc = -1, first_rd_cyc = -1;
  logic        busy_seen = 1'b0, done_busy = 1'b0, rd_overlap = 1'b0;

  mem_dump_reader #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_word(out_word),
    .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ mem_seed;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // Synchronous byte memory: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem_byte(mem_addr);
    else           mem_rdata <= 8'($urandom);
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_q.push_back(mem_addr);
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      if (out_valid) rd_overlap = 1'b1;
    end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && out_ready) begin
      ra_q.push_back(out_addr);
      rw_q.push_back(out_word);
      rl_q.push_back(out_last);
      rc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      if (done_cyc < 0) done_cyc = cyc;
      if (busy) done_busy = 1'b1;
    end
    if (busy) busy_seen = 1'b1;
  end

  task automatic clear_mon();
    rd_q.delete(); ra_q.delete(); rw_q.delete(); rl_q.delete(); rc_q.delete();
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; first_rd_cyc = -1;
    busy_seen = 1'b0; done_busy = 1'b0; rd_overlap = 1'b0;
  endtask

  task automatic run_dump(input logic [31:0] b, input logic [15:0] n,
                          output int c0, output logic timed_out);
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = n; c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < int'(n) * 60 + 100; i++) begin
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk);
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, mem_rd_en, out_valid, out_last} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags got=%b want=00000", {busy, done, mem_rd_en, out_valid, out_last});
    end
    vectors++;
    if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    vectors++;
    if (out_addr !== 32'h0) begin miscompares++; $display("FAIL reset_out_addr got=%h want=0", out_addr); end
    vectors++;
    if (out_word !== 32'h0) begin miscompares++; $display("FAIL reset_out_word got=%h want=0", out_word); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int c0; logic to;
    logic [7:0] img [8] = '{8'h13, 8'h00, 8'hA0, 8'hFF, 8'h93, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < 8; i++) mem_ovr[32'(i)] = img[i];
    ready_mode = 0;
    run_dump(32'h0, 16'd2, c0, to);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL basic_timeout got=%b want=0", to); end
    vectors++;
    if (ra_q.size() !== 2) begin
      miscompares++; $display("FAIL basic_nrec got=%0d want=2", ra_q.size());
    end else begin
      vectors++;
      if ({ra_q[0], rw_q[0], rl_q[0]} !== {32'h0, 32'hFFA00013, 1'b0}) begin
        miscompares++; $display("FAIL basic_rec0 got=%h/%h/%b want=0/ffa00013/0", ra_q[0], rw_q[0], rl_q[0]);
      end
      vectors++;
      if ({ra_q[1], rw_q[1], rl_q[1]} !== {32'h4, 32'h00100093, 1'b1}) begin
        miscompares++; $display("FAIL basic_rec1 got=%h/%h/%b want=4/00100093/1", ra_q[1], rw_q[1], rl_q[1]);
      end
      vectors++;
      if (done_cyc !== rc_q[1] + 1) begin
        miscompares++; $display("FAIL basic_done_cyc got=%0d want=%0d", done_cyc, rc_q[1] + 1);
      end
    end
    vectors++;
    if (first_rd_cyc !== c0 + 1) begin
      miscompares++; $display("FAIL basic_first_rd got=%0d want=%0d", first_rd_cyc, c0 + 1);
    end
    vectors++;
    if (first_valid_cyc !== c0 + 6) begin
      miscompares++; $display("FAIL basic_first_valid got=%0d want=%0d", first_valid_cyc, c0 + 6);
    end
    vectors++;
    if ({done_cnt == 1, done_busy} !== 2'b10) begin
      miscompares++; $display("FAIL basic_done got=cnt%0d/busy%b want=cnt1/busy0", done_cnt, done_busy);
    end
    vectors++;
    if (rd_q.size() !== 8) begin
      miscompares++; $display("FAIL basic_nreads got=%0d want=8", rd_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (rd_q[i] !== 32'(i)) begin miscompares++; $display("FAIL basic_rd%0d got=%h want=%h", i, rd_q[i], i); end
      end
    end
  endtask

  task automatic test_backpressure();
    int c0; logic to;
    ready_mode = 2;
    fork
      run_dump(32'h0, 16'd2, c0, to);
      begin
        logic [31:0] a0, w0; logic l0;
        for (int k = 0; k < 200 && out_valid !== 1'b1; k++) @(negedge clk);
        a0 = out_addr; w0 = out_word; l0 = out_last;
        vectors++;
        if ({a0, w0, l0} !== {32'h0, 32'hFFA00013, 1'b0}) begin
          miscompares++; $display("FAIL bp_first got=%h/%h/%b want=0/ffa00013/0", a0, w0, l0);
        end
        repeat (10) begin
          @(negedge clk);
          vectors++;
          if ({out_valid, mem_rd_en, out_addr, out_word, out_last} !== {2'b10, a0, w0, l0}) begin
            miscompares++;
            $display("FAIL bp_hold got=v%b/rd%b/%h/%h/%b want=v1/rd0/%h/%h/%b",
                     out_valid, mem_rd_en, out_addr, out_word, out_last, a0, w0, l0);
          end
        end
        ready_mode = 0;
      end
    join
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL bp_timeout got=%b want=0", to); end
    vectors++;
    if (ra_q.size() !== 2) begin
      miscompares++; $display("FAIL bp_nrec got=%0d want=2", ra_q.size());
    end else begin
      vectors++;
      if ({ra_q[0], rw_q[0], ra_q[1], rw_q[1], rl_q[1]} !== {32'h0, 32'hFFA00013, 32'h4, 32'h00100093, 1'b1}) begin
        miscompares++; $display("FAIL bp_recs got=%h/%h %h/%h/%b want=0/ffa00013 4/00100093/1",
                                ra_q[0], rw_q[0], ra_q[1], rw_q[1], rl_q[1]);
      end
    end
    vectors++;
    if (rd_overlap !== 1'b0) begin miscompares++; $display("FAIL bp_read_while_valid got=%b want=0", rd_overlap); end
  endtask

  task automatic test_zero_count();
    int c0; logic to;
    ready_mode = 0;
    run_dump($urandom, 16'd0, c0, to);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL zero_timeout got=%b want=0", to); end
    vectors++;
    if (done_cyc !== c0 + 1) begin miscompares++; $display("FAIL zero_done_cyc got=%0d want=%0d", done_cyc, c0 + 1); end
    vectors++;
    if ({busy_seen, rd_q.size() != 0, first_valid_cyc >= 0, done_cnt == 1} !== 4'b0001) begin
      miscompares++; $display("FAIL zero_activity got=busy%b reads%0d valid_cyc%0d done%0d want=busy0 reads0 valid_cyc-1 done1",
                              busy_seen, rd_q.size(), first_valid_cyc, done_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] bases [2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC};
    logic [31:0] exp_a1 [2] = '{32'h0000_0002, 32'h0000_0000};
    ready_mode = 0;
    for (int t = 0; t < 2; t++) begin
      int c0; logic to;
      run_dump(bases[t], 16'd2, c0, to);
      vectors++;
      if (to !== 1'b0) begin miscompares++; $display("FAIL wrap%0d_timeout got=%b want=0", t, to); end
      vectors++;
      if (rd_q.size() !== 8) begin
        miscompares++; $display("FAIL wrap%0d_nreads got=%0d want=8", t, rd_q.size());
      end else begin
        for (int i = 0; i < 8; i++) begin
          logic [31:0] ea;
          ea = bases[t] + 32'(4 * (i / 4)) + 32'(i % 4);
          vectors++;
          if (rd_q[i] !== ea) begin miscompares++; $display("FAIL wrap%0d_rd%0d got=%h want=%h", t, i, rd_q[i], ea); end
        end
      end
      vectors++;
      if (ra_q.size() !== 2) begin
        miscompares++; $display("FAIL wrap%0d_nrec got=%0d want=2", t, ra_q.size());
      end else begin
        vectors++;
        if ({ra_q[0], ra_q[1]} !== {bases[t], exp_a1[t]}) begin
          miscompares++; $display("FAIL wrap%0d_addrs got=%h,%h want=%h,%h", t, ra_q[0], ra_q[1], bases[t], exp_a1[t]);
        end
        vectors++;
        if ({rw_q[0], rw_q[1]} !== {exp_word(bases[t]), exp_word(exp_a1[t])}) begin
          miscompares++; $display("FAIL wrap%0d_words got=%h,%h want=%h,%h", t, rw_q[0], rw_q[1],
                                  exp_word(bases[t]), exp_word(exp_a1[t]));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int c0; logic to;
    logic [31:0] b;
    ready_mode = 0;
    clear_mon();
    b = $urandom;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100 && rd_q.size() < 7; k++) @(negedge clk);
    vectors++;
    if (rd_q.size() !== 7) begin miscompares++; $display("FAIL rstmid_reach got=%0d want=7", rd_q.size()); end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, mem_rd_en, out_valid, out_last, mem_addr, out_addr, out_word} !== 101'b0) begin
      miscompares++; $display("FAIL rstmid_outputs got=%b%b%b%b%b/%h/%h/%h want=all zero",
                              busy, done, mem_rd_en, out_valid, out_last, mem_addr, out_addr, out_word);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    vectors++;
    if ({done_cnt, ra_q.size()} !== {32'd0, 32'd1}) begin
      miscompares++; $display("FAIL rstmid_abandon got=done%0d recs%0d want=done0 recs1", done_cnt, ra_q.size());
    end
    b = $urandom;
    run_dump(b, 16'd2, c0, to);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL rstmid_restart_timeout got=%b want=0", to); end
    vectors++;
    if (ra_q.size() !== 2) begin
      miscompares++; $display("FAIL rstmid_restart_nrec got=%0d want=2", ra_q.size());
    end else begin
      vectors++;
      if ({ra_q[0], rw_q[0], ra_q[1], rw_q[1]} !== {b, exp_word(b), b + 32'd4, exp_word(b + 32'd4)}) begin
        miscompares++; $display("FAIL rstmid_restart_recs got=%h/%h %h/%h want=%h/%h %h/%h", ra_q[0], rw_q[0],
                                ra_q[1], rw_q[1], b, exp_word(b), b + 32'd4, exp_word(b + 32'd4));
      end
    end
  endtask

  task automatic test_start_ignored();
    int c0; logic to;
    logic [31:0] b;
    b = $urandom;
    ready_mode = 0;
    fork
      run_dump(b, 16'd3, c0, to);
      begin
        for (int k = 0; k < 50 && busy !== 1'b1; k++) @(negedge clk);
        start = 1'b1; base_addr = ~b; word_count = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 200 && done !== 1'b1; k++) @(negedge clk);
        start = 1'b1; base_addr = ~b; word_count = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL ign_timeout got=%b want=0", to); end
    vectors++;
    if ({done_cnt, rd_q.size(), ra_q.size()} !== {32'd1, 32'd12, 32'd3}) begin
      miscompares++; $display("FAIL ign_counts got=done%0d reads%0d recs%0d want=done1 reads12 recs3",
                              done_cnt, rd_q.size(), ra_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        logic [31:0] ea;
        ea = b + 32'(4 * i);
        vectors++;
        if ({ra_q[i], rw_q[i], rl_q[i]} !== {ea, exp_word(ea), i == 2}) begin
          miscompares++; $display("FAIL ign_rec%0d got=%h/%h/%b want=%h/%h/%b", i, ra_q[i], rw_q[i], rl_q[i],
                                  ea, exp_word(ea), i == 2);
        end
      end
    end
  endtask

  task automatic test_random();
    ready_mode = 1;
    for (int t = 0; t < 6; t++) begin
      int c0; logic to;
      logic [31:0] b;
      int n;
      mem_seed = 8'($urandom);
      b = $urandom;
      n = $urandom_range(1, 5);
      run_dump(b, 16'(n), c0, to);
      vectors++;
      if (to !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_timeout got=%b want=0", t, to); end
      vectors++;
      if ({ra_q.size(), rd_q.size(), done_cnt, 31'd0, rd_overlap} !== {n, 4 * n, 32'd1, 32'd0}) begin
        miscompares++; $display("FAIL rnd%0d_counts got=recs%0d reads%0d done%0d ovl%b want=recs%0d reads%0d done1 ovl0",
                                t, ra_q.size(), rd_q.size(), done_cnt, rd_overlap, n, 4 * n);
      end else begin
        for (int i = 0; i < n; i++) begin
          logic [31:0] ea;
          ea = b + 32'(4 * i);
          vectors++;
          if ({ra_q[i], rw_q[i], rl_q[i]} !== {ea, exp_word(ea), i == n - 1}) begin
            miscompares++; $display("FAIL rnd%0d_rec%0d got=%h/%h/%b want=%h/%h/%b", t, i, ra_q[i], rw_q[i], rl_q[i],
                                    ea, exp_word(ea), i == n - 1);
          end
        end
      end
    end
    ready_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_wrap();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
